// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush sequencer for a 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// It handles load-use bubbles, taken-branch redirects and data-memory waits.
// It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int LU_STALLS   = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             id_br_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             back_stall_o,
    output logic             mem_wb_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             timeout_o
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0]      LU_RELOAD = 2'(LU_STALLS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    state_t            eff_state;
    logic [1:0]        lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              hazard;

    // Load in EX whose destination is a live source of the ID instruction; x0 never counts
    assign hazard = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Once memory is no longer busy, MEM_WAIT acts as the saved state in the same cycle
    assign eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;

    // State register with resume state and remaining load-use bubble count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= RUN;
            resume_q <= RUN;
            lu_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Next-state logic: memory wait first, then load-use bubbles, and branches need no state
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        lu_cnt_d = lu_cnt_q;
        if (mem_busy_i) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                resume_d = state_q;
            end
        end else begin
            case (eff_state)
                LU_STALL: begin
                    if (lu_cnt_q <= 2'd1) begin
                        state_d  = RUN;
                        lu_cnt_d = 2'd0;
                    end else begin
                        state_d  = LU_STALL;
                        lu_cnt_d = lu_cnt_q - 2'd1;
                    end
                end
                default: begin
                    if (hazard && (LU_STALLS > 1)) begin
                        state_d  = LU_STALL;
                        lu_cnt_d = LU_RELOAD;
                    end else begin
                        state_d  = RUN;
                    end
                end
            endcase
        end
    end

    // Control outputs: zero while in reset, otherwise busy > bubble > redirect
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        back_stall_o   = 1'b0;
        mem_wb_flush_o = 1'b0;
        if (rst_i) begin
            if (mem_busy_i) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                back_stall_o   = 1'b1;
                mem_wb_flush_o = 1'b1;
            end else if ((eff_state == LU_STALL) || hazard) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end else if (id_br_taken_i) begin
                if_id_flush_o  = 1'b1;
            end
        end
    end

    // Consecutive-busy counter and the sticky timeout it arms
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q <= '0;
            timeout_o  <= 1'b0;
        end else if (mem_busy_i) begin
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
            if (wait_cnt_q >= WAIT_LAST) begin
                timeout_o <= 1'b1;
            end
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Saturating statistics of PC-stall cycles and IF/ID-flush cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (pc_stall_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (if_id_flush_o && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed bench driving two instances from shared inputs:
// u_a uses LU_STALLS=1, MEM_TIMEOUT=64 and CNT_W=16.
// u_b uses LU_STALLS=2, MEM_TIMEOUT=8 and CNT_W=4.
// Control outputs are packed {pc_stall, if_id_stall, if_id_flush, id_ex_flush, back_stall, mem_wb_flush}.
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_BR   = 6'b001000;
    localparam logic [5:0] C_BUSY = 6'b110011;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, id_br_taken, mem_busy;

    logic        a_pc, a_ifs, a_iff, a_idf, a_bs, a_mwf, a_to;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_ifs, b_iff, b_idf, b_bs, b_mwf, b_to;
    logic [3:0]  b_stall, b_flush;
    logic [5:0]  ctrl_a, ctrl_b;

    int test_count = 0;
    int fail_count = 0;

    assign ctrl_a = {a_pc, a_ifs, a_iff, a_idf, a_bs, a_mwf};
    assign ctrl_b = {b_pc, b_ifs, b_iff, b_idf, b_bs, b_mwf};

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.LU_STALLS(1), .MEM_TIMEOUT(64), .CNT_W(16)) u_a (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
        .id_br_taken_i(id_br_taken), .mem_busy_i(mem_busy),
        .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .if_id_flush_o(a_iff),
        .id_ex_flush_o(a_idf), .back_stall_o(a_bs), .mem_wb_flush_o(a_mwf),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_flush), .timeout_o(a_to)
    );

    pipe_hazard_ctrl #(.LU_STALLS(2), .MEM_TIMEOUT(8), .CNT_W(4)) u_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
        .id_br_taken_i(id_br_taken), .mem_busy_i(mem_busy),
        .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff),
        .id_ex_flush_o(b_idf), .back_stall_o(b_bs), .mem_wb_flush_o(b_mwf),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_flush), .timeout_o(b_to)
    );

    // Drive one cycle's worth of inputs and let the combinational outputs settle
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic [4:0] rd, input logic mr,
                                 input logic br, input logic busy);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd       = rd;
        ex_memread  = mr;
        id_br_taken = br;
        mem_busy    = busy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic doCycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset held with every control input active: outputs must stay at zero
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        doCycle();
        checkOutput("reset_ctrl_a", ctrl_a, C_NONE);
        checkOutput("reset_ctrl_b", ctrl_b, C_NONE);
        checkOutput("reset_stall_a", a_stall, 0);
        checkOutput("reset_flush_a", a_flush, 0);
        checkOutput("reset_to_a", a_to, 0);
        checkOutput("reset_stall_b", b_stall, 0);
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        doCycle();
        rst_i = 1'b1;

        // Load-use hazard on rs2 = x5
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_a", ctrl_a, C_LU);
        checkOutput("lu_b", ctrl_b, C_LU);
        doCycle();
        // Unrelated load in EX now: u_a clear, u_b still bubbling
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_clear_a", ctrl_a, C_NONE);
        checkOutput("lu_second_b", ctrl_b, C_LU);
        checkOutput("lu_stall_cnt_a", a_stall, 1);
        checkOutput("lu_stall_cnt_b1", b_stall, 1);
        doCycle();
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_run_b", ctrl_b, C_NONE);
        checkOutput("lu_run_a", ctrl_a, C_NONE);
        checkOutput("lu_stall_cnt_b2", b_stall, 2);
        doCycle();

        // Load into x0 is never a hazard
        applyStimulus(5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("x0_a", ctrl_a, C_NONE);
        checkOutput("x0_b", ctrl_b, C_NONE);
        doCycle();

        // Taken branch, no hazard
        applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        checkOutput("br_a", ctrl_a, C_BR);
        checkOutput("br_b", ctrl_b, C_BR);
        doCycle();
        applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("br_done_a", ctrl_a, C_NONE);
        checkOutput("br_flush_cnt_a", a_flush, 1);
        checkOutput("br_flush_cnt_b", b_flush, 1);
        checkOutput("br_stall_cnt_a", a_stall, 1);
        doCycle();

        // Hazard together with a branch: the branch waits for the bubble
        applyStimulus(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("lubr_a", ctrl_a, C_LU);
        checkOutput("lubr_b", ctrl_b, C_LU);
        doCycle();
        applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        checkOutput("lubr_redirect_a", ctrl_a, C_BR);
        checkOutput("lubr_bubble_b", ctrl_b, C_LU);
        doCycle();
        applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        checkOutput("lubr_redirect_b", ctrl_b, C_BR);
        checkOutput("lubr_flush_cnt_a", a_flush, 2);
        checkOutput("lubr_stall_cnt_b", b_stall, 4);
        doCycle();

        // Memory wait during the last load-use bubble of u_b
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("mw_lu_b", ctrl_b, C_LU);
        doCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            checkOutput("mw_busy_a", ctrl_a, C_BUSY);
            checkOutput("mw_busy_b", ctrl_b, C_BUSY);
            doCycle();
        end
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mw_resume_a", ctrl_a, C_NONE);
        checkOutput("mw_resume_b", ctrl_b, C_LU);
        doCycle();
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mw_run_b", ctrl_b, C_NONE);
        checkOutput("mw_stall_cnt_a", a_stall, 6);
        checkOutput("mw_stall_cnt_b", b_stall, 9);
        checkOutput("mw_flush_cnt_a", a_flush, 3);
        checkOutput("mw_no_to_a", a_to, 0);
        checkOutput("mw_no_to_b", b_to, 0);
        doCycle();

        // Long memory wait: u_b times out after 8 cycles, u_a after 64
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            doCycle();
            if (i == 7)  checkOutput("to_b_before", b_to, 0);
            if (i == 8)  checkOutput("to_b_at", b_to, 1);
            if (i == 63) checkOutput("to_a_before", a_to, 0);
            if (i == 64) checkOutput("to_a_at", a_to, 1);
        end
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_release_a", ctrl_a, C_NONE);
        checkOutput("to_release_b", ctrl_b, C_NONE);
        checkOutput("to_stall_cnt_a", a_stall, 70);
        checkOutput("sat_stall_cnt_b", b_stall, 15);
        doCycle();
        checkOutput("to_sticky_a", a_to, 1);
        checkOutput("to_sticky_b", b_to, 1);

        // Reset while u_b waits on memory with a bubble pending
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        doCycle();
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_pre_busy_b", ctrl_b, C_BUSY);
        doCycle();
        rst_i = 1'b0;
        #1;
        checkOutput("rst_ctrl_a", ctrl_a, C_NONE);
        checkOutput("rst_ctrl_b", ctrl_b, C_NONE);
        checkOutput("rst_stall_a", a_stall, 0);
        checkOutput("rst_flush_a", a_flush, 0);
        checkOutput("rst_to_a", a_to, 0);
        checkOutput("rst_stall_b", b_stall, 0);
        checkOutput("rst_to_b", b_to, 0);
        doCycle();
        rst_i = 1'b1;
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_a", ctrl_a, C_NONE);
        checkOutput("post_rst_b", ctrl_b, C_NONE);
        doCycle();
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_rst_br_b", ctrl_b, C_BR);
        doCycle();
        checkOutput("post_rst_flush_a", a_flush, 1);
        checkOutput("post_rst_stall_b", b_stall, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
